// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcodes and ALU encodings for the multicycle MIPS controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/aludec.sv
// rtl/aludec.sv - ALU decoder: aluop and funct to alucontrol
module aludec
  import mc_pkg::*;
#(
  parameter int FNW = 6
) (
  input  logic [1:0]     aluop,
  input  logic [FNW-1:0] funct,
  output logic [2:0]     alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control unit: Moore FSM plus ALU decoder
module mc_controller
  import mc_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  output logic           memtoreg,
  output logic           regdst,
  output logic           iord,
  output logic           pcsrc,
  output logic           alusrcA,
  output logic [1:0]     alusrcB,
  output logic           irwrite,
  output logic           memwrite,
  output logic           regwrite,
  output logic           jump,
  output logic           pcen,
  output logic [2:0]     alucontrol,
  output logic [3:0]     state,
  output logic           illegal
);

  state_t     cur, nxt;
  logic [1:0] aluop;
  logic       pcwrite, branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // Outputs decode from the state register, so an async reset clears them at once
  always_comb begin
    nxt      = S_FETCH;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    iord     = 1'b0;
    pcsrc    = 1'b0;
    alusrcA  = 1'b0;
    alusrcB  = 2'b00;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    jump     = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    case (cur)
      S_FETCH: begin
        alusrcB = 2'b01;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        nxt     = S_DECODE;
      end
      S_DECODE: begin
        alusrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default: begin
            nxt     = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
        if (op == OP_LW)      nxt = S_MEMRD;
        else if (op == OP_SW) nxt = S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        nxt  = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrcA = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 1'b1;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        jump    = 1'b1;
        pcwrite = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = cur;

  aludec #(.FNW(FNW)) u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized self-checking bench for mc_controller
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       memtoreg, regdst, iord, pcsrc, alusrcA, irwrite, memwrite, regwrite, jump, pcen, illegal;
  logic [1:0] alusrcB;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  mc_controller #(.OPW(6), .FNW(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .pcsrc(pcsrc),
    .alusrcA(alusrcA), .alusrcB(alusrcB), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .jump(jump), .pcen(pcen), .alucontrol(alucontrol),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {memtoreg,regdst,iord,pcsrc,alusrcA,alusrcB,irwrite,memwrite,regwrite,jump} per state
  function automatic logic [10:0] exp_ctrl(input int s);
    case (s)
      0:       return 11'b00000_01_1000;
      1:       return 11'b00000_11_0000;
      2:       return 11'b00001_10_0000;
      3:       return 11'b00100_00_0000;
      4:       return 11'b10000_00_0010;
      5:       return 11'b00100_00_0100;
      6:       return 11'b00001_00_0000;
      7:       return 11'b01000_00_0010;
      8:       return 11'b00011_00_0000;
      9:       return 11'b00001_10_0000;
      10:      return 11'b00000_00_0010;
      11:      return 11'b00000_00_0001;
      default: return 11'b0;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input int s, input logic [5:0] fn);
    if (s == 8) return 3'b110;
    if (s != 6) return 3'b010;
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  task automatic check_outputs(input string tag, input int s);
    logic [10:0] ctrl;
    ctrl = {memtoreg, regdst, iord, pcsrc, alusrcA, alusrcB, irwrite, memwrite, regwrite, jump};
    check_val({tag, ".state"}, 32'(state), 32'(s));
    check_val({tag, ".ctrl"}, 32'(ctrl), 32'(exp_ctrl(s)));
    check_val({tag, ".pcen"}, 32'(pcen), 32'((s == 0) || (s == 11) || (s == 8 && zero)));
    check_val({tag, ".alucontrol"}, 32'(alucontrol), 32'(exp_alu(s, funct)));
    check_val({tag, ".illegal"}, 32'(illegal), 32'(s == 1 && !is_legal(op)));
  endtask

  // Entered one tick after a rising edge with the DUT in FETCH; returns the same way
  task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input int zmode);
    int seq[$];
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000100: seq = '{0, 1, 8};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = '{0, 1};
    endcase
    op    = o;
    funct = fn;
    foreach (seq[i]) begin
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      check_outputs($sformatf("op%02h_c%0d", o, i), seq[i]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    logic [5:0] ro, rf;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    repeat (3) begin
      @(posedge clk);
      #1;
      check_outputs("reset_hold", 0);
    end
    reset = 1'b1;

    run_instr(6'b100011, 6'b000000, 2);
    run_instr(6'b101011, 6'b000000, 2);
    run_instr(6'b000000, 6'b101010, 2);
    run_instr(6'b000000, 6'b100100, 2);
    run_instr(6'b000100, 6'b000000, 1);
    run_instr(6'b000100, 6'b000000, 0);
    run_instr(6'b111111, 6'b000000, 2);
    run_instr(6'b001000, 6'b000000, 2);
    run_instr(6'b000010, 6'b000000, 2);

    for (int n = 0; n < 80; n++) begin
      ro = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      rf = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(ro, rf, 2);
    end

    op = 6'b101011;
    zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("sw_reach_memwr.state", 32'(state), 32'd5);
    check_val("sw_reach_memwr.memwrite", 32'(memwrite), 32'd1);
    reset = 1'b0;
    #1;
    check_val("reset_mid.memwrite", 32'(memwrite), 32'd0);
    check_outputs("reset_mid", 0);
    @(posedge clk);
    #1;
    check_outputs("reset_mid_hold", 0);
    reset = 1'b1;
    run_instr(6'b100011, 6'b000000, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit: Moore FSM plus ALU decoder.
- Sits directly upstream of the multicycle datapath. Consumes instr opcode/funct and ALU zero; drives every datapath mux select, register enable and the memory write strobe.
- Supports R-type (add, sub, and, or, slt), lw, sw, beq, addi and j.

Parameters:
- OPW, 6, opcode field width
- FNW, 6, funct field width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag from datapath
- memtoreg  out  1  1 = register write data from data register
- regdst  out  1  1 = write register is rd
- iord  out  1  1 = memory address from aluout
- pcsrc  out  1  1 = next PC from aluout (branch target)
- alusrcA  out  1  1 = ALU A from A register
- alusrcB  out  2  00 = B reg, 01 = 4, 10 = signimm, 11 = signimm<<2
- irwrite  out  1  instruction register enable
- memwrite  out  1  data memory write strobe
- regwrite  out  1  register file write enable
- jump  out  1  select jump target for PC
- pcen  out  1  PC enable = pcwrite | (branch & zero)
- alucontrol  out  3  ALU operation
- state  out  4  current FSM state (debug/verification)
- illegal  out  1  high in DECODE when op is unsupported

Behaviour:
- State register updates on clk rising edge. reset low forces FETCH asynchronously.
- All outputs are combinational from state only (Moore), except:
  - alucontrol, which also depends on funct;
  - pcen, which depends on zero in BRANCH;
  - illegal, which depends on op in DECODE.
- Outputs not listed for a state are 0.
- Reset values (state = FETCH): irwrite=1, pcen=1, alusrcB=01, alucontrol=010; all other outputs 0; state=0.
- FETCH (0): alusrcB=01, aluop=00, irwrite=1, pcwrite=1. Next state: DECODE.
- DECODE (1): alusrcB=11, aluop=00. Next state by op:
  - lw 100011 or sw 101011 -> MEMADR
  - R 000000 -> EXECUTE
  - beq 000100 -> BRANCH
  - addi 001000 -> ADDIEX
  - j 000010 -> JUMP
  - any other op -> FETCH, with illegal=1 for that cycle
- MEMADR (2): alusrcA=1, alusrcB=10, aluop=00. Next state: MEMRD if lw, MEMWR if sw.
- MEMRD (3): iord=1. Next state: MEMWB.
- MEMWB (4): memtoreg=1, regwrite=1, regdst=0. Next state: FETCH.
- MEMWR (5): iord=1, memwrite=1. Next state: FETCH.
- EXECUTE (6): alusrcA=1, alusrcB=00, aluop=10. Next state: ALUWB.
- ALUWB (7): regdst=1, regwrite=1. Next state: FETCH.
- BRANCH (8): alusrcA=1, alusrcB=00, aluop=01, pcsrc=1, branch=1. Next state: FETCH.
- ADDIEX (9): alusrcA=1, alusrcB=10, aluop=00. Next state: ADDIWB.
- ADDIWB (10): regdst=0, regwrite=1. Next state: FETCH.
- JUMP (11): jump=1, pcwrite=1. Next state: FETCH.
- Codes 12-15 are unreachable; if entered, next state is FETCH with all outputs 0.
- op/funct are sampled in DECODE, MEMADR and EXECUTE only. IR is not rewritten between FETCH cycles, so they are stable.
- Instruction latency in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- ALU decoder:
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub)
  - aluop 10, by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - aluop 10 with unknown funct -> 010
  - aluop 11 -> 010
- beq not taken: pcen=0 in BRANCH and PC holds the fetch-incremented value.
- Reset asserted mid-instruction: state returns to FETCH immediately; a pending memwrite/regwrite deasserts combinationally in the same cycle.

Decomposition:
- mc_pkg holds:
  - state enum (4-bit, explicit codes 0-11)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - aluop encodings
  - alucontrol codes ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111
- One sub-module, aludec (aluop, funct -> alucontrol). It is combinational and instantiated once.
- The FSM and output decode stay in mc_controller.

Test Plan:
- Hold reset low, toggle clk -> state=0, irwrite=1, pcen=1, alusrcB=01, alucontrol=010 every cycle; release reset -> state=1 next edge.
- op=100011 (lw) -> states 0,1,2,3,4; iord=1 in state 3; memtoreg=1 and regwrite=1 in state 4; back to 0.
- op=101011 (sw) -> states 0,1,2,5; memwrite=1 only in state 5; regwrite never asserted.
- op=000000, funct=101010 -> alucontrol=111 in EXECUTE; regdst=1 and regwrite=1 in ALUWB. Repeat with funct=100100 -> 000.
- op=000100 with zero=1 -> pcen=1, pcsrc=1, alucontrol=110 in BRANCH; same with zero=0 -> pcen=0.
- op=111111 -> illegal=1 in DECODE, next state 0. Separately, assert reset during MEMWR -> memwrite drops at once and state=0.
